// File: rtl/branch_outcome_queue.sv
// In-order tracking queue for in-flight predicted conditional branches.
// Entries are allocated by fetch, resolved out of order by execute, and retired in program order.
module branch_outcome_queue #(
  parameter int DEPTH = 8,
  parameter int IDXW  = 10,
  parameter int TAGW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc_valid,
  input  logic [IDXW-1:0] alloc_idx,
  input  logic            alloc_pred,
  output logic            alloc_ready,
  output logic [TAGW-1:0] alloc_tag,
  input  logic            res_valid,
  input  logic [TAGW-1:0] res_tag,
  input  logic            res_taken,
  output logic            upd_valid,
  output logic [IDXW-1:0] upd_idx,
  output logic            upd_taken,
  output logic            mispredict,
  output logic [TAGW:0]   count
);

  localparam logic [TAGW:0]   CNT_ONE  = (TAGW+1)'(1);
  localparam logic [TAGW:0]   CNT_ZERO = '0;
  localparam logic [TAGW:0]   CNT_FULL = (TAGW+1)'(DEPTH);
  localparam logic [TAGW-1:0] TAG_ONE  = TAGW'(1);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] ent_pred;
  logic [DEPTH-1:0] ent_taken;
  logic [IDXW-1:0]  ent_idx [DEPTH];

  logic [TAGW-1:0] head;
  logic [TAGW-1:0] tail;

  logic            retire;
  logic            res_ok;
  logic            mis;
  logic            alloc_ok;
  logic [TAGW-1:0] res_dist;
  logic [TAGW:0]   count_n;
  logic [DEPTH-1:0] younger;

  // Retire looks only at registered done bits, so a resolve to the head retires one edge later.
  always_comb begin
    retire   = ent_valid[head] & ent_done[head];
    res_ok   = res_valid & ent_valid[res_tag] & ~ent_done[res_tag];
    mis      = res_ok & (res_taken != ent_pred[res_tag]);
    alloc_ok = alloc_valid & alloc_ready & ~mis;
    res_dist = res_tag - head;
    if (mis) begin
      count_n = {1'b0, res_dist} + CNT_ONE - (retire ? CNT_ONE : CNT_ZERO);
    end else begin
      count_n = count + (alloc_ok ? CNT_ONE : CNT_ZERO) - (retire ? CNT_ONE : CNT_ZERO);
    end
    younger = '0;
    for (int i = 0; i < DEPTH; i++) begin
      younger[i] = (TAGW'(i) - head) > res_dist;
    end
  end

  assign alloc_tag = tail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid   <= '0;
      ent_done    <= '0;
      ent_pred    <= '0;
      ent_taken   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_idx[i] <= '0;
      end
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      alloc_ready <= 1'b1;
      upd_valid   <= 1'b0;
      upd_idx     <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
    end else begin
      if (alloc_ok) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        ent_pred[tail]  <= alloc_pred;
        ent_idx[tail]   <= alloc_idx;
      end
      if (res_ok) begin
        ent_done[res_tag]  <= 1'b1;
        ent_taken[res_tag] <= res_taken;
      end
      if (mis) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (younger[i]) ent_valid[i] <= 1'b0;
        end
      end
      if (retire) begin
        ent_valid[head] <= 1'b0;
        head            <= head + TAG_ONE;
        upd_idx         <= ent_idx[head];
        upd_taken       <= ent_taken[head];
      end
      if (mis) tail <= res_tag + TAG_ONE;
      else if (alloc_ok) tail <= tail + TAG_ONE;
      count       <= count_n;
      alloc_ready <= (count_n != CNT_FULL);
      upd_valid   <= retire;
      mispredict  <= mis;
    end
  end

endmodule
